adder_result_sink: RTL and testbench
====================================

# adder_result_sink

Receiving end of the adder's result stream. Captures every `valid`-qualified `c` word the adder produces into a small FIFO, keeps a running sum and a count of accepted results, and hands words to a downstream reader over a ready/valid handshake. The adder has no back-pressure, so overflow is detected and flagged rather than stalled.

## Interface
- `C_W`, default 7: result word width; matches adder `c`.
- `DEPTH`, default 8: FIFO entries; power of two, at least 2.
- `ACC_W`, default 16: running-sum width.
- `CNT_W`, default 16: accepted-result counter width.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the `clk` rising edge.
- `valid`  in  1  adder result strobe; one word per cycle while high.
- `c`  in  C_W  adder result, sampled when `valid`=1.
- `clr`  in  1  synchronous soft clear (active-high).
- `out_ready`  in  1  reader accepts head word.
- `out_valid`  out  1  FIFO non-empty.
- `out_data`  out  C_W  FIFO head word.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `acc`  out  ACC_W  sum of all accepted words.
- `n_acc`  out  CNT_W  number of accepted words.
- `drop_err`  out  1  sticky; set when a word was dropped because the FIFO was full.

## Operation
- Storage: circular buffer, `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits wrapping DEPTH-1→0, plus occupancy register `level`.
- push = `valid` & (level<DEPTH | pop). pop = `out_valid` & `out_ready`.
- Push: `mem[wr_ptr]`←`c`, `wr_ptr`++. Pop: `rd_ptr`++.
- `level`: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full, `valid`=1, no pop: word dropped, `drop_err`←1, no other state changes.
- Full, `valid`=1, pop in the same cycle: the pop frees a slot. The word is accepted and there is no drop.
- Empty, `valid`=1, `out_ready`=1: no bypass. The word is written and `out_valid` rises the next cycle.
- `out_data` = `mem[rd_ptr]` (first-word-fall-through, combinational from storage). `out_data` is don't-care when `out_valid`=0.
- On every accepted push:
  - `acc`←`acc`+zero-extended `c`, modulo 2^ACC_W (wraps silently).
  - `n_acc`←`n_acc`+1, modulo 2^CNT_W.
- Dropped words do not update `acc` or `n_acc`.
- `clr`=1:
  - Clears pointers, `level`, `acc`, `n_acc` and `drop_err`.
  - Takes priority over a push and a pop in the same cycle; that cycle's `valid` word is discarded and does not set `drop_err`.
- `reset`=0: same effect as `clr`, and has priority over everything. Storage contents are not cleared.
- Reset values: `out_valid`=0, `level`=0, `acc`=0, `n_acc`=0, `drop_err`=0.
- A reset mid-stream discards all buffered words. The first `valid` after `reset` returns to 1 is captured normally.

## Timing
- Input-to-output latency is 1 cycle. A word sampled at edge N drives `out_valid`/`out_data` after edge N.
- `acc`, `n_acc`, `level` and `drop_err` are registered and reflect edge N after that edge.
- Handshake:
  - Transfer occurs on the edge where `out_valid`&`out_ready`=1.
  - `out_data` is stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` never deasserts without a transfer, except on `clr` or reset.
- Sustained throughput: one push and one pop per cycle.

## Test plan
- Reset then single word: hold `reset`=0 for 2 edges, then `valid`=1, `c`=7'd30 for one cycle with `out_ready`=0 → next cycle `out_valid`=1, `out_data`=30, `level`=1, `acc`=30, `n_acc`=1.
- Ordering: push 5, 9, 21 on consecutive cycles with `out_ready`=1 → `out_data` sequence 5, 9, 21 on successive transfers; `level` returns to 0; `acc`=35.
- Overflow: `out_ready`=0, push 10 words 1..10 → `level`=8, `drop_err`=1, `acc`=36, `n_acc`=8; draining yields 1..8.
- Full with simultaneous push and pop: fill to 8, then `valid`=1, `c`=99, `out_ready`=1 → no drop, `level` stays 8, `drop_err` stays 0, 99 is read last.
- Accumulator wrap with `ACC_W`=8: push 127, 127, 10 → `acc`=8 (264 mod 256), `n_acc`=3.
- Clear/reset mid-stream: with 4 words buffered, assert `clr` with `valid`=1, `c`=50 → next cycle `level`=0, `out_valid`=0, `acc`=0, `drop_err`=0. Repeat with `reset`=0 for the same outcome.

Source files
------------

// File: rtl/adder_result_sink.sv
// adder_result_sink: captures the adder's result stream into a FIFO,
// keeps a running sum and count, and flags drops on overflow.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous active-low reset
//   valid, c   adder result strobe and word
//   clr        synchronous soft clear
//   out_ready  reader accepts head word
//   out_valid  FIFO non-empty
//   out_data   FIFO head word (fall-through)
//   level      occupancy 0..DEPTH
//   acc        wrapping sum of accepted words
//   n_acc      wrapping count of accepted words
//   drop_err   sticky overflow flag
module adder_result_sink #(
  parameter int C_W   = 7,
  parameter int DEPTH = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid,
  input  logic [C_W-1:0]           c,
  input  logic                     clr,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [C_W-1:0]           out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [ACC_W-1:0]         acc,
  output logic [CNT_W-1:0]         n_acc,
  output logic                     drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [C_W-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  logic full;
  logic pop;
  logic push;
  logic drop;
  logic wipe;

  assign wipe      = ~reset | clr;
  assign full      = (level == LW'(DEPTH));
  assign out_valid = (level != '0);
  assign out_data  = mem[rd_ptr];

  // A pop in the same cycle frees the slot a full FIFO needs.
  assign pop  = out_valid & out_ready;
  assign push = valid & (~full | pop);
  assign drop = valid & ~push;

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (push && !wipe) begin
      mem[wr_ptr] <= c;
    end
  end

  always_ff @(posedge clk) begin
    if (wipe) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      acc      <= '0;
      n_acc    <= '0;
      drop_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        acc    <= acc + ACC_W'(c);
        n_acc  <= n_acc + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (drop) begin
        drop_err <= 1'b1;
      end
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_result_sink.sv
// tb_adder_result_sink: random and directed stimulus checked
// against a queue-based model of the result sink.
module tb_adder_result_sink;

  localparam int C_W   = 7;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic valid = 1'b0;
  logic [C_W-1:0] c = '0;
  logic clr = 1'b0;
  logic out_ready = 1'b0;

  logic out_valid;
  logic [C_W-1:0] out_data;
  logic [3:0] level;
  logic [15:0] acc;
  logic [15:0] n_acc;
  logic drop_err;

  logic out_valid8;
  logic [C_W-1:0] out_data8;
  logic [3:0] level8;
  logic [7:0] acc8;
  logic [15:0] n_acc8;
  logic drop_err8;

  always #5 clk = ~clk;

  adder_result_sink #(
    .C_W(C_W), .DEPTH(DEPTH), .ACC_W(16), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .valid(valid), .c(c),
    .clr(clr), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data),
    .level(level), .acc(acc), .n_acc(n_acc),
    .drop_err(drop_err)
  );

  adder_result_sink #(
    .C_W(C_W), .DEPTH(DEPTH), .ACC_W(8), .CNT_W(16)
  ) dut8 (
    .clk(clk), .reset(reset), .valid(valid), .c(c),
    .clr(clr), .out_ready(out_ready),
    .out_valid(out_valid8), .out_data(out_data8),
    .level(level8), .acc(acc8), .n_acc(n_acc8),
    .drop_err(drop_err8)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  int    mq[$];
  longint m_acc = 0;
  longint m_n = 0;
  bit    m_drop = 1'b0;

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               name, act, exp, $time);
    end
  endtask

  // Model: advances on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    bit p_pop;
    bit p_push;
    if (!reset || clr) begin
      mq.delete();
      m_acc = 0;
      m_n = 0;
      m_drop = 1'b0;
    end else begin
      p_pop = (mq.size() > 0) && out_ready;
      p_push = valid && ((mq.size() < DEPTH) || p_pop);
      if (valid && !p_push) m_drop = 1'b1;
      if (p_pop) void'(mq.pop_front());
      if (p_push) begin
        mq.push_back(int'(c));
        m_acc = m_acc + longint'(c);
        m_n = m_n + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("out_valid", out_valid, mq.size() > 0);
      chk("level", level, mq.size());
      if (mq.size() > 0) chk("out_data", out_data, mq[0]);
      chk("acc", acc, m_acc % 65536);
      chk("acc8", acc8, m_acc % 256);
      chk("n_acc", n_acc, m_n % 65536);
      chk("drop_err", drop_err, m_drop);
      chk("level8", level8, mq.size());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int v);
    valid = 1'b1;
    c = C_W'(v);
    tick();
    valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  int exp_seq[9];

  initial begin
    reset = 1'b0;
    tick();
    tick();
    armed = 1'b1;
    chk("rst_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_acc", acc, 0);
    chk("rst_nacc", n_acc, 0);
    chk("rst_drop", drop_err, 0);
    reset = 1'b1;

    out_ready = 1'b0;
    push(30);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 30);
    chk("single_level", level, 1);
    chk("single_acc", acc, 30);
    chk("single_nacc", n_acc, 1);

    do_clr();
    out_ready = 1'b1;
    push(5);
    chk("ord_d0", out_data, 5);
    push(9);
    chk("ord_d1", out_data, 9);
    push(21);
    chk("ord_d2", out_data, 21);
    tick();
    chk("ord_level", level, 0);
    chk("ord_acc", acc, 35);

    do_clr();
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) push(i);
    chk("ovf_level", level, 8);
    chk("ovf_drop", drop_err, 1);
    chk("ovf_acc", acc, 36);
    chk("ovf_nacc", n_acc, 8);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_drain", out_data, i);
      tick();
    end
    out_ready = 1'b0;

    do_clr();
    for (int i = 1; i <= 8; i++) push(i);
    valid = 1'b1;
    c = 7'd99;
    out_ready = 1'b1;
    tick();
    valid = 1'b0;
    out_ready = 1'b0;
    chk("fpp_level", level, 8);
    chk("fpp_drop", drop_err, 0);
    for (int i = 0; i < 7; i++) exp_seq[i] = i + 2;
    exp_seq[7] = 99;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("fpp_drain", out_data, exp_seq[i]);
      tick();
    end
    out_ready = 1'b0;

    do_clr();
    push(127);
    push(127);
    push(10);
    chk("wrap_acc8", acc8, 8);
    chk("wrap_nacc8", n_acc8, 3);
    chk("wrap_acc16", acc, 264);

    do_clr();
    for (int i = 0; i < 4; i++) push(40 + i);
    clr = 1'b1;
    valid = 1'b1;
    c = 7'd50;
    tick();
    clr = 1'b0;
    valid = 1'b0;
    chk("clr_level", level, 0);
    chk("clr_valid", out_valid, 0);
    chk("clr_acc", acc, 0);
    chk("clr_drop", drop_err, 0);

    for (int i = 0; i < 4; i++) push(60 + i);
    reset = 1'b0;
    valid = 1'b1;
    c = 7'd50;
    tick();
    reset = 1'b1;
    valid = 1'b0;
    chk("rstm_level", level, 0);
    chk("rstm_valid", out_valid, 0);
    chk("rstm_acc", acc, 0);
    chk("rstm_drop", drop_err, 0);
    push(17);
    chk("rstm_first", out_data, 17);

    for (int i = 0; i < 3000; i++) begin
      valid = ($urandom_range(0, 3) != 0);
      c = C_W'($urandom);
      out_ready = ($urandom_range(0, 9) < ((i / 300) % 2 ? 8 : 3));
      clr = ($urandom_range(0, 199) == 0);
      reset = ($urandom_range(0, 299) != 0);
      tick();
    end
    valid = 1'b0;
    clr = 1'b0;
    reset = 1'b1;
    tick();
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
